// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage RISC-V pipeline.
// Combines load-use, multi-cycle EX, data-memory wait, taken-branch and trap
// sources into per-stage stall/flush controls and a fetch redirect.
module hazard_controller #(
    parameter int TRAP_SETTLE = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_busy,
    input  logic             ex_br_taken,
    input  logic [63:0]      ex_br_target,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             mem_trap,
    input  logic [63:0]      mem_trap_target,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             flush_mem,
    output logic             redirect_valid,
    output logic [63:0]      redirect_pc,
    output logic [CNT_W-1:0] stall_cycles
);

    // Settle counter wide enough to hold TRAP_SETTLE (at least one bit when it is 0).
    localparam int SET_W = $clog2(TRAP_SETTLE + 2);
    localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(TRAP_SETTLE);

    typedef enum logic [1:0] {
        S_RUN,
        S_MEM_WAIT,
        S_TRAP_SETTLE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [SET_W-1:0]   r_settle_cnt;
    logic [SET_W-1:0]   w_settle_cnt_next;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [63:0]        r_redir_pc;
    logic               r_lu_done;

    logic               w_trap;
    logic               w_mem_wait;
    logic               w_branch;
    logic               w_load_use;
    logic               w_lu_fire;
    logic               w_stall_if;
    logic               w_stall_id;
    logic               w_stall_ex;
    logic               w_stall_mem;
    logic               w_flush_id;
    logic               w_flush_ex;
    logic               w_flush_mem;
    logic               w_redir;
    logic [63:0]        w_redir_pc;

    // A trap waits for its own memory access to complete before it is taken.
    assign w_mem_wait = mem_req & ~mem_ready;
    assign w_trap     = mem_trap & ~w_mem_wait;
    assign w_branch   = ex_valid & ex_br_taken;
    // r_lu_done limits a load-use bubble to a single cycle for a given pair.
    assign w_load_use = ex_valid & ex_is_load & (ex_rd != 5'd0) & id_valid & ~r_lu_done &
                        ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    // Next-state and per-cycle pipeline controls, everything forced to 0 while in reset.
    always_comb begin
        w_state_next      = r_state;
        w_settle_cnt_next = r_settle_cnt;
        w_lu_fire         = 1'b0;
        w_stall_if        = 1'b0;
        w_stall_id        = 1'b0;
        w_stall_ex        = 1'b0;
        w_stall_mem       = 1'b0;
        w_flush_id        = 1'b0;
        w_flush_ex        = 1'b0;
        w_flush_mem       = 1'b0;
        w_redir           = 1'b0;
        w_redir_pc        = mem_trap_target;
        if (rst_n) begin
            if (r_state == S_TRAP_SETTLE && !w_trap) begin
                // Fetch held while mtvec/mepc settle; nothing fetched may enter ID.
                w_stall_if = 1'b1;
                w_flush_id = 1'b1;
                if (r_settle_cnt != '0) begin
                    w_settle_cnt_next = r_settle_cnt - 1'b1;
                end
                if (r_settle_cnt <= SET_W'(1)) begin
                    w_state_next = S_RUN;
                end
            end else if (w_trap) begin
                w_flush_id        = 1'b1;
                w_flush_ex        = 1'b1;
                w_flush_mem       = 1'b1;
                w_redir           = 1'b1;
                w_redir_pc        = mem_trap_target;
                w_settle_cnt_next = SETTLE_INIT;
                w_state_next      = (TRAP_SETTLE == 0) ? S_RUN : S_TRAP_SETTLE;
            end else if (w_mem_wait) begin
                w_stall_if   = 1'b1;
                w_stall_id   = 1'b1;
                w_stall_ex   = 1'b1;
                w_stall_mem  = 1'b1;
                w_state_next = S_MEM_WAIT;
            end else begin
                w_state_next = S_RUN;
                if (ex_busy) begin
                    w_stall_if  = 1'b1;
                    w_stall_id  = 1'b1;
                    w_stall_ex  = 1'b1;
                    w_flush_mem = 1'b1;
                end else if (w_branch) begin
                    // The ID instruction is on the wrong path, so a branch beats load-use.
                    w_flush_id = 1'b1;
                    w_flush_ex = 1'b1;
                    w_redir    = 1'b1;
                    w_redir_pc = ex_br_target;
                end else if (w_load_use) begin
                    w_stall_if = 1'b1;
                    w_stall_id = 1'b1;
                    w_flush_ex = 1'b1;
                    w_lu_fire  = 1'b1;
                end
            end
        end
    end

    // State, settle counter, load-use marker and last redirect target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_RUN;
            r_settle_cnt <= '0;
            r_lu_done    <= 1'b0;
            r_redir_pc   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_settle_cnt <= w_settle_cnt_next;
            r_lu_done    <= w_lu_fire;
            if (w_redir) begin
                r_redir_pc <= w_redir_pc;
            end
        end
    end

    // Saturating count of cycles in which fetch was stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall_if && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_if       = w_stall_if;
    assign stall_id       = w_stall_id;
    assign stall_ex       = w_stall_ex;
    assign stall_mem      = w_stall_mem;
    assign flush_id       = w_flush_id;
    assign flush_ex       = w_flush_ex;
    assign flush_mem      = w_flush_mem;
    assign redirect_valid = w_redir;
    assign redirect_pc    = w_redir ? w_redir_pc : r_redir_pc;
    assign stall_cycles   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: a default instance (TRAP_SETTLE=2, 32-bit
// counter) and a second one (TRAP_SETTLE=0, 2-bit counter) driven by the same inputs.
`timescale 1ns/1ps
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_use_rs1, id_use_rs2;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_valid, ex_is_load, ex_busy, ex_br_taken;
    logic [63:0] ex_br_target, mem_trap_target;
    logic        mem_req, mem_ready, mem_trap;

    logic        stall_if, stall_id, stall_ex, stall_mem;
    logic        flush_id, flush_ex, flush_mem, redirect_valid;
    logic [63:0] redirect_pc;
    logic [31:0] stall_cycles;

    logic        b_stall_if, b_stall_id, b_stall_ex, b_stall_mem;
    logic        b_flush_id, b_flush_ex, b_flush_mem, b_redirect_valid;
    logic [63:0] b_redirect_pc;
    logic [1:0]  b_stall_cycles;

    logic [7:0]  ctrl, b_ctrl;
    assign ctrl   = {stall_if, stall_id, stall_ex, stall_mem,
                     flush_id, flush_ex, flush_mem, redirect_valid};
    assign b_ctrl = {b_stall_if, b_stall_id, b_stall_ex, b_stall_mem,
                     b_flush_id, b_flush_ex, b_flush_mem, b_redirect_valid};

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_ctrl = 8'h00;
    logic [31:0] exp_sc   = 32'd0;

    always #5 clk = ~clk;

    hazard_controller #(.TRAP_SETTLE(2), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_busy(ex_busy), .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .mem_trap(mem_trap), .mem_trap_target(mem_trap_target),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall_cycles(stall_cycles)
    );

    hazard_controller #(.TRAP_SETTLE(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_busy(ex_busy), .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .mem_trap(mem_trap), .mem_trap_target(mem_trap_target),
        .stall_if(b_stall_if), .stall_id(b_stall_id), .stall_ex(b_stall_ex),
        .stall_mem(b_stall_mem),
        .flush_id(b_flush_id), .flush_ex(b_flush_ex), .flush_mem(b_flush_mem),
        .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
        .stall_cycles(b_stall_cycles)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Control bits in order {stall_if,id,ex,mem, flush_id,ex,mem, redirect_valid}.
    task automatic check_ctrl(input string tag, input logic [7:0] exp);
        exp_ctrl = exp;
        #2;
        check(tag, 64'(ctrl), 64'(exp));
    endtask

    task automatic tick();
        if (exp_ctrl[7]) exp_sc = exp_sc + 32'd1;
        exp_ctrl = 8'h00;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
        ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_busy = 0; ex_br_taken = 0;
        ex_br_target = 64'h0; mem_req = 0; mem_ready = 0; mem_trap = 0;
        mem_trap_target = 64'h0;
    endtask

    task automatic load_use_rs1(input logic [4:0] rd, input logic [4:0] rs1, input logic use1);
        clr_inputs();
        ex_valid = 1; ex_is_load = 1; ex_rd = rd;
        id_valid = 1; id_use_rs1 = use1; id_rs1 = rs1;
    endtask

    initial begin
        clr_inputs();
        rst_n = 1'b0;
        #2;
        check("reset_ctrl", 64'(ctrl), 64'h0);
        check("reset_pc", redirect_pc, 64'h0);
        check("reset_cnt", 64'(stall_cycles), 64'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // lw x5 in EX, add reading x5 in ID: one bubble, then nothing even if held
        load_use_rs1(5'd5, 5'd5, 1'b1);
        check_ctrl("lu_rs1", 8'b1100_0100);
        tick();
        check_ctrl("lu_one_cycle", 8'b0000_0000);
        check("lu_cnt", 64'(stall_cycles), 64'(exp_sc));
        tick();
        clr_inputs();
        check_ctrl("idle", 8'b0000_0000);
        tick();

        // x0 never hazards; unused rs1 never hazards; rs2 match does
        load_use_rs1(5'd0, 5'd0, 1'b1);
        check_ctrl("lu_x0", 8'b0000_0000);
        tick();
        load_use_rs1(5'd5, 5'd5, 1'b0);
        check_ctrl("lu_unused", 8'b0000_0000);
        tick();
        load_use_rs1(5'd7, 5'd3, 1'b1);
        id_use_rs2 = 1; id_rs2 = 5'd7;
        check_ctrl("lu_rs2", 8'b1100_0100);
        tick();

        // memory wait for 3 cycles suppresses a taken branch, which is taken on mem_ready
        clr_inputs();
        mem_req = 1; ex_valid = 1; ex_br_taken = 1; ex_br_target = 64'h0000_0000_0000_1234;
        for (int i = 0; i < 3; i++) begin
            check_ctrl("mem_wait", 8'b1111_0000);
            tick();
        end
        mem_ready = 1;
        check_ctrl("mem_done_branch", 8'b0000_1101);
        check("mem_done_pc", redirect_pc, 64'h1234);
        tick();
        check("mem_wait_cnt", 64'(stall_cycles), 64'(exp_sc));
        clr_inputs();
        check_ctrl("after_branch", 8'b0000_0000);
        check("pc_hold", redirect_pc, 64'h1234);
        tick();

        // ex_busy outranks a load-use hazard
        load_use_rs1(5'd9, 5'd9, 1'b1);
        ex_busy = 1;
        check_ctrl("ex_busy", 8'b1110_0010);
        tick();

        // branch beats a simultaneous load-use
        load_use_rs1(5'd9, 5'd9, 1'b1);
        ex_br_taken = 1; ex_br_target = 64'h0000_0000_0000_4000;
        check_ctrl("branch_over_lu", 8'b0000_1101);
        check("branch_pc", redirect_pc, 64'h4000);
        tick();

        // trap: redirect, then 2 settle cycles, then RUN
        clr_inputs();
        mem_trap = 1; mem_trap_target = 64'h0000_0000_8000_0100;
        check_ctrl("trap", 8'b0000_1111);
        check("trap_pc", redirect_pc, 64'h8000_0100);
        tick();
        clr_inputs();
        check_ctrl("settle1", 8'b1000_1000);
        check("settle_b_none", 64'(b_ctrl), 64'h0);
        check("settle_pc_hold", redirect_pc, 64'h8000_0100);
        tick();
        check_ctrl("settle2", 8'b1000_1000);
        tick();
        check_ctrl("settle_done", 8'b0000_0000);
        tick();

        // trap together with a branch: trap target only, MEM flushed
        clr_inputs();
        mem_trap = 1; mem_trap_target = 64'h0000_0000_8000_0200;
        ex_valid = 1; ex_br_taken = 1; ex_br_target = 64'h0000_0000_0000_DEAD;
        check_ctrl("trap_and_branch", 8'b0000_1111);
        check("trap_and_branch_pc", redirect_pc, 64'h8000_0200);
        tick();
        // new trap during settle restarts the sequence
        clr_inputs();
        mem_trap = 1; mem_trap_target = 64'h0000_0000_0000_0300;
        check_ctrl("trap_restart", 8'b0000_1111);
        check("trap_restart_pc", redirect_pc, 64'h300);
        tick();
        clr_inputs();
        check_ctrl("restart_settle1", 8'b1000_1000);
        tick();
        check_ctrl("restart_settle2", 8'b1000_1000);
        tick();
        check_ctrl("restart_done", 8'b0000_0000);
        check("cnt_total", 64'(stall_cycles), 64'(exp_sc));
        check("cnt_saturate", 64'(b_stall_cycles), 64'h3);
        tick();

        // reset asserted in MEM_WAIT clears everything at once
        mem_req = 1;
        check_ctrl("pre_reset_wait", 8'b1111_0000);
        tick();
        check_ctrl("pre_reset_wait2", 8'b1111_0000);
        rst_n = 1'b0;
        #1;
        check("async_rst_ctrl", 64'(ctrl), 64'h0);
        check("async_rst_cnt", 64'(stall_cycles), 64'h0);
        check("async_rst_pc", redirect_pc, 64'h0);
        exp_ctrl = 8'h00;
        exp_sc = 32'd0;
        tick();
        rst_n = 1'b1;
        clr_inputs();
        check_ctrl("post_reset_idle", 8'b0000_0000);
        tick();
        check("post_reset_cnt", 64'(stall_cycles), 64'h0);
        ex_valid = 1; ex_br_taken = 1; ex_br_target = 64'h0000_0000_0000_0040;
        check_ctrl("post_reset_branch", 8'b0000_1101);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
